// File: rtl/plot_sched_pkg.sv
// -----------------------------------------------------------------------------
// plot_sched_pkg
//   Shared definitions for player_plot_scheduler:
//   - sched_state_e : scheduler FSM state encoding
//   - pos_width     : width of one packed {x,y} position slice
//   - player_colour : fixed colour per player index
// -----------------------------------------------------------------------------
package plot_sched_pkg;

  // ST_GRANT is the first cycle a player pixel is presented, ST_HOLD is any
  // following cycle in which the sink has not yet accepted it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_HOLD  = 2'b10,
    ST_CLEAR = 2'b11
  } sched_state_e;

  // Width of one {x,y} slice on the packed position bus.
  function automatic int pos_width(input int x_w, input int y_w);
    return x_w + y_w;
  endfunction

  // Colour drawn for each player channel.
  function automatic logic [2:0] player_colour(input logic [2:0] idx);
    logic [2:0] col;
    case (idx)
      3'd0:    col = 3'b001;
      3'd1:    col = 3'b010;
      3'd2:    col = 3'b100;
      3'd3:    col = 3'b110;
      3'd4:    col = 3'b011;
      3'd5:    col = 3'b101;
      3'd6:    col = 3'b111;
      default: col = 3'b111;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/player_plot_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker: returns the lowest-index requester at or
//   after ptr_i+1, wrapping modulo N.
//   Ports:
//     req_i  [N]  request vector
//     ptr_i  [IW] index of the most recently granted requester
//     gnt_o  [IW] selected index (valid only when any_o=1)
//     any_o       at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    int raw;
    int idx;
    raw   = 0;
    idx   = 0;
    gnt_o = '0;
    any_o = |req_i;
    for (int k = N; k >= 1; k--) begin
      raw   = int'(ptr_i) + k;
      idx   = (raw >= N) ? (raw - N) : raw;
      gnt_o = req_i[idx[IW-1:0]] ? idx[IW-1:0] : gnt_o;
    end
  end

endmodule

// File: rtl/player_plot_scheduler.sv
// -----------------------------------------------------------------------------
// player_plot_scheduler
//   Funnels per-player position updates into the single pixel-write port of
//   the VGA adapter. Updates are coalesced per player, granted round-robin and
//   emitted one pixel per grant over a plot/plot_ready handshake. Optionally
//   sweeps the whole framebuffer to BG_COLOUR.
//
//   Build option: define PLOT_SCHED_CLEAR_EN to include the clear sweep, the
//   clear latch and the busy flag. Without it clear_req is ignored and busy=0.
//
//   Ports:
//     CLOCK_50    clock, rising edge
//     reset       asynchronous active-high reset
//     pos         packed {x,y} per player, player i in slice i
//     pos_update  per-player strobe: slice i is new
//     clear_req   strobe: start a framebuffer clear
//     plot_ready  sink accepts the current pixel
//     x, y        pixel coordinates
//     colour      pixel colour
//     plot        pixel valid
//     busy        clear sweep in progress
//     overrun     sticky per player: update arrived while already pending
// -----------------------------------------------------------------------------
module player_plot_scheduler
  import plot_sched_pkg::*;
#(
  parameter int         NUM_PLAYERS = 4,
  parameter int         X_W         = 8,
  parameter int         Y_W         = 7,
  parameter int         X_MAX       = 159,
  parameter int         Y_MAX       = 119,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic                                 CLOCK_50,
  input  logic                                 reset,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]     pos,
  input  logic [NUM_PLAYERS-1:0]               pos_update,
  input  logic                                 clear_req,
  input  logic                                 plot_ready,
  output logic [X_W-1:0]                       x,
  output logic [Y_W-1:0]                       y,
  output logic [2:0]                           colour,
  output logic                                 plot,
  output logic                                 busy,
  output logic [NUM_PLAYERS-1:0]               overrun
);

  localparam int PW = pos_width(X_W, Y_W);
  localparam int IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic [PW-1:0]          shadow_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] pending_q, pending_d;
  logic [NUM_PLAYERS-1:0] overrun_q, overrun_d;
  logic [NUM_PLAYERS-1:0] grant_mask_s;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gnt_s;
  logic                   any_s;
  logic [PW-1:0]          gshadow_s;

  sched_state_e           state_q, state_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [2:0]             colour_q, colour_d;
  logic                   plot_q, plot_d;

  logic                   grant_fire_s;
  logic                   enter_clear_s;
  logic                   clear_pend_s;

  rr_arbiter #(
    .N  (NUM_PLAYERS),
    .IW (IW)
  ) u_arb (
    .req_i (pending_q),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .any_o (any_s)
  );

  assign gshadow_s = shadow_q[gnt_s];

  // One-hot of the player being granted on this edge (empty when no grant).
  always_comb begin
    grant_mask_s = '0;
    if (grant_fire_s) begin
      grant_mask_s[gnt_s] = 1'b1;
    end else begin
      grant_mask_s = '0;
    end
  end

  // A granted player leaves pending unless a fresh update lands on the same
  // edge; only an update to a still-waiting player counts as an overrun.
  assign pending_d = (pending_q & ~grant_mask_s) | pos_update;
  assign overrun_d = overrun_q | (pos_update & pending_q & ~grant_mask_s);
  assign ptr_d     = grant_fire_s ? gnt_s : ptr_q;

`ifdef PLOT_SCHED_CLEAR_EN
  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

  logic clr_latch_q, clr_latch_d;
  logic busy_q;

  // clear_req is only consulted outside the sweep, so a request that arrives
  // during a sweep is dropped.
  assign clear_pend_s = clear_req | clr_latch_q;
  assign clr_latch_d  = (clr_latch_q | (clear_req & (state_q != ST_CLEAR))) & ~enter_clear_s;

  // Clear latch and busy flag.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clr_latch_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clr_latch_q <= clr_latch_d;
      busy_q      <= (state_d == ST_CLEAR);
    end
  end

  assign busy = busy_q;
`else
  localparam int unused_sweep_dims = X_MAX + Y_MAX;
  logic unused_clear_s;

  assign unused_clear_s = clear_req;
  assign clear_pend_s   = 1'b0;
  assign busy           = 1'b0;
`endif

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    plot_d        = plot_q;
    grant_fire_s  = 1'b0;
    enter_clear_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        plot_d = 1'b0;
        if (clear_pend_s) begin
          enter_clear_s = 1'b1;
        end else if (any_s) begin
          grant_fire_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT, ST_HOLD: begin
        if (!plot_ready) begin
          state_d = ST_HOLD;
        end else if (clear_pend_s) begin
          enter_clear_s = 1'b1;
        end else if (any_s) begin
          grant_fire_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
          plot_d  = 1'b0;
        end
      end

`ifdef PLOT_SCHED_CLEAR_EN
      // x/y double as the raster counters while sweeping.
      ST_CLEAR: begin
        if (!plot_ready) begin
          state_d = ST_CLEAR;
        end else if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
          if (any_s) begin
            grant_fire_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            plot_d  = 1'b0;
          end
        end else if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        plot_d  = 1'b0;
      end
    endcase

    if (enter_clear_s) begin
      state_d  = ST_CLEAR;
      x_d      = '0;
      y_d      = '0;
      colour_d = BG_COLOUR;
      plot_d   = 1'b1;
    end else if (grant_fire_s) begin
      state_d  = ST_GRANT;
      x_d      = gshadow_s[PW-1 -: X_W];
      y_d      = gshadow_s[Y_W-1:0];
      colour_d = player_colour(3'(gnt_s));
      plot_d   = 1'b1;
    end else begin
      state_d  = state_d;
    end
  end

  // Per-player shadow positions; a same-edge grant reads the old value.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (pos_update[i]) begin
          shadow_q[i] <= pos[i*PW +: PW];
        end
      end
    end
  end

  // FSM state, registered pixel outputs and request bookkeeping.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= 3'b000;
      plot_q    <= 1'b0;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= IW'(NUM_PLAYERS - 1);
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_player_plot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_player_plot_scheduler
//   Directed scenarios plus randomized traffic, each cycle compared against a
//   pixel-level reference model (pending flags, shadows, round-robin pointer,
//   clear sweep position) kept in plain integer arrays.
// -----------------------------------------------------------------------------
module tb_player_plot_scheduler;

  localparam int NP = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int PW = XW + YW;
  localparam int XM = 159;
  localparam int YM = 119;
  localparam int BG = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*PW-1:0]  pos;
  logic [NP-1:0]     upd;
  logic              clr;
  logic              rdy;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [2:0]        colour;
  logic              plot;
  logic              busy;
  logic [NP-1:0]     overrun;

  always #5 clk = ~clk;

  player_plot_scheduler #(
    .NUM_PLAYERS (NP),
    .X_W         (XW),
    .Y_W         (YW),
    .X_MAX       (XM),
    .Y_MAX       (YM),
    .BG_COLOUR   (3'b000)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .pos        (pos),
    .pos_update (upd),
    .clear_req  (clr),
    .plot_ready (rdy),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_pend [NP];
  int          m_sx   [NP];
  int          m_sy   [NP];
  int          m_ptr;
  bit          m_show;
  bit          m_clr;
  bit          m_latch;
  int          e_x, e_y, e_col;
  bit          e_plot, e_busy;
  bit [NP-1:0] e_ovr;

  function automatic int col_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 6;
      4:       return 3;
      5:       return 5;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_pend[i] = 0;
      m_sx[i]   = 0;
      m_sy[i]   = 0;
    end
    m_ptr = NP - 1; m_show = 0; m_clr = 0; m_latch = 0;
    e_x = 0; e_y = 0; e_col = 0; e_plot = 0; e_busy = 0; e_ovr = '0;
  endtask

  // One clock edge of the model, using the inputs present during that cycle.
  task automatic model_step();
    bit free, was_clr, want;
    int g, c;
    was_clr = m_clr;
    free    = 0;
    g       = -1;
    if (!m_show) free = 1;
    else if (rdy) begin
      if (m_clr) begin
        if (e_x == XM && e_y == YM) begin
          m_clr = 0; e_busy = 0; free = 1;
        end else if (e_x == XM) begin
          e_x = 0; e_y = e_y + 1;
        end else begin
          e_x = e_x + 1;
        end
      end else free = 1;
    end
    want = 0;
`ifdef PLOT_SCHED_CLEAR_EN
    want = m_latch || (clr && !was_clr);
`endif
    if (free && want && !was_clr) begin
      m_clr = 1; m_show = 1; m_latch = 0;
      e_x = 0; e_y = 0; e_col = BG; e_plot = 1; e_busy = 1;
    end else begin
      if (want && !was_clr) m_latch = 1;
      if (free) begin
        for (int k = 1; k <= NP; k++) begin
          c = (m_ptr + k) % NP;
          if (g < 0 && m_pend[c]) g = c;
        end
        if (g >= 0) begin
          e_x = m_sx[g]; e_y = m_sy[g]; e_col = col_of(g);
          e_plot = 1; m_show = 1; m_pend[g] = 0; m_ptr = g;
        end else begin
          e_plot = 0; m_show = 0;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (upd[i]) begin
        if (m_pend[i]) e_ovr[i] = 1'b1;
        m_sx[i]   = int'(pos[i*PW+YW +: XW]);
        m_sy[i]   = int'(pos[i*PW +: YW]);
        m_pend[i] = 1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_all(input string tag);
    logic [23:0] act, exp;
    act = {x, y, colour, plot, busy, overrun};
    exp = {XW'(e_x), YW'(e_y), 3'(e_col), e_plot, e_busy, e_ovr};
    check_eq(tag, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all("cycle_outputs");
    upd = '0;
    clr = 1'b0;
  endtask

  task automatic set_pos(input int i, input logic [XW-1:0] xv, input logic [YW-1:0] yv);
    pos[i*PW +: PW] = {xv, yv};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic reset_midway();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_plot", plot, 1'b0);
    check_eq("async_rst_busy", busy, 1'b0);
    check_all("async_rst_outputs");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("post_rst_no_plot", plot, 1'b0);
  endtask

  logic [XW-1:0] bx [NP];
  int            busy_cycles;
  int            last_x, last_y;

  initial begin
    rst = 1'b1; pos = '0; upd = '0; clr = 1'b0; rdy = 1'b1;
    tick();
    tick();
    check_eq("reset_plot", plot, 1'b0);
    check_eq("reset_xy", {x, y}, '0);
    check_eq("reset_colour", colour, 3'b000);
    check_eq("reset_overrun", overrun, '0);
    check_eq("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single update latency.
    set_pos(0, 8'd10, 7'd20);
    upd = 4'b0001;
    tick();
    check_eq("lat_t1_plot", plot, 1'b0);
    tick();
    check_eq("lat_plot", plot, 1'b1);
    check_eq("lat_x", x, 8'd10);
    check_eq("lat_y", y, 7'd20);
    check_eq("lat_colour", colour, 3'b001);
    tick();
    check_eq("lat_one_cycle", plot, 1'b0);

    // Burst of four in round-robin order from a fresh pointer.
    do_reset();
    for (int i = 0; i < NP; i++) begin
      bx[i] = XW'(30 + 7 * i);
      set_pos(i, bx[i], YW'(i + 1));
    end
    upd = 4'b1111;
    tick();
    for (int i = 0; i < NP; i++) begin
      tick();
      check_eq("burst_plot", plot, 1'b1);
      check_eq("burst_x", x, bx[i]);
    end
    tick();
    check_eq("burst_end", plot, 1'b0);
    set_pos(0, 8'd70, 7'd1);
    set_pos(3, 8'd73, 7'd2);
    upd = 4'b1001;
    tick();
    tick();
    check_eq("pair_first_x", x, 8'd70);
    tick();
    check_eq("pair_second_x", x, 8'd73);
    check_eq("pair_second_col", colour, 3'b110);
    tick();

    // Stall with a coalesced update behind it.
    set_pos(0, 8'd1, 7'd1);
    set_pos(1, 8'd5, 7'd5);
    upd = 4'b0011;
    tick();
    tick();
    check_eq("stall_first_x", x, 8'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        set_pos(1, 8'd6, 7'd6);
        upd = 4'b0010;
      end
      tick();
      check_eq("stall_hold", {x, y, colour, plot}, {8'd1, 7'd1, 3'b001, 1'b1});
    end
    rdy = 1'b1;
    tick();
    check_eq("stall_next_xy", {x, y}, {8'd6, 7'd6});
    check_eq("stall_next_col", colour, 3'b010);
    tick();
    check_eq("coalesce_single", plot, 1'b0);
    check_eq("overrun_bits", overrun, 4'b0010);

`ifdef PLOT_SCHED_CLEAR_EN
    // Full sweep with a player update arriving mid-way.
    clr = 1'b1;
    tick();
    check_eq("clr_first", {x, y, colour, plot, busy}, {8'd0, 7'd0, 3'b000, 1'b1, 1'b1});
    busy_cycles = 0;
    last_x = 0;
    last_y = 0;
    for (int i = 0; i < 20000 && busy; i++) begin
      busy_cycles++;
      last_x = int'(x);
      last_y = int'(y);
      if (i == 5000) begin
        set_pos(2, 8'd33, 7'd44);
        upd = 4'b0100;
      end
      tick();
    end
    check_eq("clr_busy_cycles", busy_cycles, 19200);
    check_eq("clr_last_x", last_x, XM);
    check_eq("clr_last_y", last_y, YM);
    check_eq("clr_then_p2", {plot, x, y}, {1'b1, 8'd33, 7'd44});
    tick();

    // Clear request during a stalled grant is served after acceptance.
    set_pos(0, 8'd12, 7'd12);
    upd = 4'b0001;
    tick();
    tick();
    rdy = 1'b0;
    clr = 1'b1;
    tick();
    check_eq("latch_hold_busy", busy, 1'b0);
    tick();
    rdy = 1'b1;
    tick();
    check_eq("latch_clear_start", {busy, x, y}, {1'b1, 8'd0, 7'd0});
    for (int i = 0; i < 1000; i++) begin
      rdy = ($urandom_range(0, 9) < 9);
      tick();
    end
    rdy = 1'b1;
    reset_midway();
`endif

    // Randomized traffic with stalls.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        upd[i] = ($urandom_range(0, 3) == 0);
        if (upd[i]) set_pos(i, XW'($urandom), YW'($urandom));
      end
      rdy = ($urandom_range(0, 9) < 7);
      tick();
    end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < NP; i++) begin
      upd[i] = 1'b1;
      set_pos(i, XW'($urandom), YW'($urandom));
    end
    tick();
    tick();
    reset_midway();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
